wash_timer: RTL and testbench
=============================

WASH_TIMER -- requirements
Module: wash_timer

Interface
REQ-001 Parameter PRESCALE, default 4, clock cycles per countdown tick; legal range 1..65535.
REQ-002 Parameter WIDTH, default 8, width of duration and remaining.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  level request from the cycle controller; high = timer wanted, low = release.
REQ-006 duration  input  WIDTH  requested tick count; sampled only when a request is accepted.
REQ-007 pause  input  1  level; high freezes an active countdown.
REQ-008 abort  input  1  level; high cancels any activity.
REQ-009 done  output  1  registered; high while the countdown has expired and start is still high.
REQ-010 busy  output  1  registered; high in RUN or PAUSED.
REQ-011 expired  output  1  registered; one-cycle pulse on entry to DONE.
REQ-012 remaining  output  WIDTH  registered; ticks left, for the front-panel display.

Function
REQ-013 The block SHALL implement the states IDLE, RUN, PAUSED and DONE, held in a registered state variable.
REQ-014 IDLE: start=1 and abort=0 -> latch remaining=duration and clear the prescale counter; go to DONE if duration==0, else go to RUN.
REQ-015 RUN: the prescale counter increments each cycle; at PRESCALE-1 it wraps to 0 and remaining decrements by 1 (one tick).
REQ-016 RUN: the tick that takes remaining from 1 to 0 SHALL move the state to DONE in that same edge.
REQ-017 RUN: pause=1 -> PAUSED; there is no tick and no prescale increment that cycle.
REQ-018 PAUSED: remaining and the prescale counter hold; pause=0 -> RUN, and counting resumes from the held prescale value.
REQ-019 DONE: done=1 and remaining=0; stay until start=0, then go to IDLE; start held high SHALL NOT retrigger.
REQ-020 Cancel priority in RUN, PAUSED and DONE: abort=1 > start=0 > pause > tick.
  - abort=1 or start=0 -> IDLE next edge, with done=0, busy=0, remaining=0, and no expired pulse.
REQ-021 In IDLE, abort=1 SHALL block acceptance even if start=1.
REQ-022 Changes on duration after acceptance SHALL be ignored until the next acceptance.
REQ-023 Latency: with start sampled at edge E0 in IDLE, duration D>0, and no pause, done SHALL be high after edge E0+D*PRESCALE.
  - D=0 -> done high after E0.
  - Each cycle spent in PAUSED adds exactly one cycle.
REQ-024 expired SHALL be high for exactly the first cycle of each DONE visit.
REQ-025 busy SHALL be 1 exactly when the state is RUN or PAUSED.
REQ-026 Back-to-back requests: start low for one cycle after done (DONE->IDLE), then high again, SHALL be accepted on the next edge with the new duration.
REQ-027 Arithmetic: remaining SHALL never underflow below 0 or wrap; the prescale counter SHALL be wide enough for PRESCALE-1 and SHALL wrap only at PRESCALE-1.
REQ-028 PRESCALE=1 -> one tick on every RUN cycle.

Reset
REQ-029 rst=1 at a rising edge SHALL force state IDLE, prescale counter 0, done=0, busy=0, expired=0, remaining=0.
REQ-030 rst SHALL override all other inputs, including a reset asserted mid-countdown or in DONE.
REQ-031 Once rst deasserts, a start that is still high SHALL be accepted as a new request at the first subsequent edge.

Verification
REQ-032 PRESCALE=4, duration=10, start held -> done rises after edge E0+40; expired pulses 1 cycle; remaining reads 10,9,...,0 with a step every 4 cycles.
REQ-033 duration=0, start=1 -> done=1 after E0 with busy never 1; start=0 -> IDLE, done=0 next edge.
REQ-034 duration=5, PRESCALE=4, pause high for 7 cycles at remaining=3 -> remaining holds 3 throughout the pause; done after E0+27.
REQ-035 duration=8 running, start dropped at remaining=4 -> IDLE next edge, remaining=0, no expired pulse.
  - Same scenario with abort instead of start drop -> same response.
REQ-036 Back-to-back: duration=3 completes, start low 1 cycle, start high with duration=2 -> second done after 2*PRESCALE edges; change duration mid-run -> no effect.
REQ-037 rst pulsed mid-count at remaining=6 -> all outputs 0 next edge; start still high after release -> a fresh countdown from the current duration.

Source files
------------

// File: rtl/wash_timer.sv
// Wash cycle countdown timer: accepts a tick count and counts it down
// at a prescaled rate, with pause, abort and release handling.
module wash_timer #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] duration,
  input  logic             pause,
  input  logic             abort,
  output logic             done,
  output logic             busy,
  output logic             expired,
  output logic [WIDTH-1:0] remaining
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] PS_MAX = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             expired_q, expired_d;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          remaining_d = duration;
          presc_d     = '0;
          state_d     = (duration == '0) ? DONE : RUN;
        end
      end
      RUN, PAUSED: begin
        if (abort || !start) begin
          state_d     = IDLE;
          remaining_d = '0;
          presc_d     = '0;
        end else if (pause) begin
          state_d = PAUSED;
        end else begin
          // Leaving PAUSED counts as a normal RUN cycle, so each paused cycle costs exactly one.
          state_d = RUN;
          if (presc_q == PS_MAX) begin
            presc_d = '0;
            if (remaining_q <= WIDTH'(1)) begin
              remaining_d = '0;
              state_d     = DONE;
            end else begin
              remaining_d = remaining_q - WIDTH'(1);
            end
          end else begin
            presc_d = presc_q + CW'(1);
          end
        end
      end
      DONE: begin
        remaining_d = '0;
        if (abort || !start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
        presc_d     = '0;
      end
    endcase
  end

  always_comb begin
    done_d    = (state_d == DONE);
    busy_d    = (state_d == RUN) || (state_d == PAUSED);
    expired_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      expired_q   <= expired_d;
    end
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign expired   = expired_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_wash_timer.sv
// Directed bench for wash_timer: PRESCALE=4 main instance plus a PRESCALE=1 instance.
module tb_wash_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] duration = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       done, busy, expired;
  logic [7:0] rem;
  logic       done1, busy1, expired1;
  logic [7:0] rem1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wash_timer #(.PRESCALE(4), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .duration(duration), .pause(pause),
    .abort(abort), .done(done), .busy(busy), .expired(expired), .remaining(rem)
  );

  wash_timer #(.PRESCALE(1), .WIDTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .duration(duration), .pause(pause),
    .abort(abort), .done(done1), .busy(busy1), .expired(expired1), .remaining(rem1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; duration = 8'd5;
    step(); step();
    checks++; if (done !== 1'b0) begin $display("FAIL reset_done got=%b exp=0", done); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", busy); failures++; end
    checks++; if (expired !== 1'b0) begin $display("FAIL reset_expired got=%b exp=0", expired); failures++; end
    checks++; if (rem !== 8'd0) begin $display("FAIL reset_remaining got=%0d exp=0", rem); failures++; end
    start = 1'b0; rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] exp_rem;
    start = 1'b1; duration = 8'd10;
    step();
    checks++; if (rem !== 8'd10 || busy !== 1'b1) begin $display("FAIL basic_accept rem=%0d busy=%b exp rem=10 busy=1", rem, busy); failures++; end
    for (int k = 1; k <= 40; k++) begin
      step();
      exp_rem = 8'(10 - k / 4);
      checks++;
      if (rem !== exp_rem || done !== (k == 40) || expired !== (k == 40) || busy !== (k < 40)) begin
        $display("FAIL basic_cycle%0d rem=%0d done=%b exp_pulse=%b busy=%b exp rem=%0d done=%b expired=%b busy=%b",
                 k, rem, done, expired, busy, exp_rem, (k == 40), (k == 40), (k < 40));
        failures++;
      end
    end
    step();
    checks++; if (done !== 1'b1 || expired !== 1'b0) begin $display("FAIL basic_hold done=%b expired=%b exp done=1 expired=0", done, expired); failures++; end
    start = 1'b0;
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || rem !== 8'd0) begin $display("FAIL basic_release done=%b busy=%b rem=%0d exp 0/0/0", done, busy, rem); failures++; end
  endtask

  task automatic test_zero();
    start = 1'b1; duration = 8'd0;
    step();
    checks++; if (done !== 1'b1 || expired !== 1'b1 || busy !== 1'b0 || rem !== 8'd0) begin
      $display("FAIL zero_accept done=%b expired=%b busy=%b rem=%0d exp 1/1/0/0", done, expired, busy, rem); failures++; end
    step();
    checks++; if (done !== 1'b1 || expired !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL zero_hold done=%b expired=%b busy=%b exp 1/0/0", done, expired, busy); failures++; end
    start = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin $display("FAIL zero_release done=%b exp=0", done); failures++; end
  endtask

  task automatic test_pause();
    start = 1'b1; duration = 8'd5;
    step();
    for (int k = 1; k <= 8; k++) step();
    checks++; if (rem !== 8'd3) begin $display("FAIL pause_pre rem=%0d exp=3", rem); failures++; end
    duration = 8'd99;
    pause = 1'b1;
    for (int k = 9; k <= 15; k++) begin
      step();
      checks++; if (rem !== 8'd3 || busy !== 1'b1 || done !== 1'b0) begin
        $display("FAIL pause_hold_e%0d rem=%0d busy=%b done=%b exp 3/1/0", k, rem, busy, done); failures++; end
    end
    pause = 1'b0;
    for (int k = 16; k <= 26; k++) step();
    checks++; if (done !== 1'b0 || rem !== 8'd1) begin $display("FAIL pause_e26 done=%b rem=%0d exp 0/1", done, rem); failures++; end
    step();
    checks++; if (done !== 1'b1 || expired !== 1'b1 || rem !== 8'd0) begin
      $display("FAIL pause_e27 done=%b expired=%b rem=%0d exp 1/1/0", done, expired, rem); failures++; end
    start = 1'b0;
    step();
  endtask

  task automatic test_cancel();
    start = 1'b1; duration = 8'd8;
    step();
    for (int k = 1; k <= 16; k++) step();
    checks++; if (rem !== 8'd4) begin $display("FAIL cancel_pre rem=%0d exp=4", rem); failures++; end
    start = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || rem !== 8'd0 || done !== 1'b0 || expired !== 1'b0) begin
      $display("FAIL cancel_start busy=%b rem=%0d done=%b expired=%b exp 0/0/0/0", busy, rem, done, expired); failures++; end
    start = 1'b1;
    step();
    for (int k = 1; k <= 16; k++) step();
    checks++; if (rem !== 8'd4) begin $display("FAIL abort_pre rem=%0d exp=4", rem); failures++; end
    abort = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || rem !== 8'd0 || done !== 1'b0 || expired !== 1'b0) begin
      $display("FAIL cancel_abort busy=%b rem=%0d done=%b expired=%b exp 0/0/0/0", busy, rem, done, expired); failures++; end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || rem !== 8'd0) begin
      $display("FAIL abort_blocks busy=%b done=%b rem=%0d exp 0/0/0", busy, done, rem); failures++; end
    abort = 1'b0; start = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; duration = 8'd3;
    step();
    for (int k = 1; k <= 12; k++) step();
    checks++; if (done !== 1'b1 || expired !== 1'b1) begin $display("FAIL b2b_first done=%b expired=%b exp 1/1", done, expired); failures++; end
    start = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin $display("FAIL b2b_gap done=%b exp=0", done); failures++; end
    start = 1'b1; duration = 8'd2;
    step();
    checks++; if (busy !== 1'b1 || rem !== 8'd2) begin $display("FAIL b2b_accept busy=%b rem=%0d exp 1/2", busy, rem); failures++; end
    duration = 8'd200;
    for (int k = 1; k <= 4; k++) step();
    checks++; if (rem !== 8'd1 || done !== 1'b0) begin $display("FAIL b2b_mid rem=%0d done=%b exp 1/0", rem, done); failures++; end
    for (int k = 5; k <= 7; k++) step();
    checks++; if (done !== 1'b0) begin $display("FAIL b2b_early done=%b exp=0", done); failures++; end
    step();
    checks++; if (done !== 1'b1 || expired !== 1'b1 || rem !== 8'd0) begin
      $display("FAIL b2b_second done=%b expired=%b rem=%0d exp 1/1/0", done, expired, rem); failures++; end
    start = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; duration = 8'd9;
    step();
    for (int k = 1; k <= 12; k++) step();
    checks++; if (rem !== 8'd6) begin $display("FAIL rstmid_pre rem=%0d exp=6", rem); failures++; end
    rst = 1'b1;
    step();
    checks++; if (rem !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || expired !== 1'b0) begin
      $display("FAIL rstmid_clear rem=%0d busy=%b done=%b expired=%b exp 0/0/0/0", rem, busy, done, expired); failures++; end
    rst = 1'b0;
    step();
    checks++; if (rem !== 8'd9 || busy !== 1'b1) begin $display("FAIL rstmid_restart rem=%0d busy=%b exp 9/1", rem, busy); failures++; end
    for (int k = 1; k <= 4; k++) step();
    checks++; if (rem !== 8'd8) begin $display("FAIL rstmid_tick rem=%0d exp=8", rem); failures++; end
    start = 1'b0;
    step();
  endtask

  task automatic test_prescale1();
    logic [7:0] exp_rem;
    start = 1'b1; duration = 8'd3;
    step();
    checks++; if (rem1 !== 8'd3 || busy1 !== 1'b1) begin $display("FAIL ps1_accept rem=%0d busy=%b exp 3/1", rem1, busy1); failures++; end
    for (int k = 1; k <= 3; k++) begin
      step();
      exp_rem = 8'(3 - k);
      checks++;
      if (rem1 !== exp_rem || done1 !== (k == 3) || expired1 !== (k == 3)) begin
        $display("FAIL ps1_cycle%0d rem=%0d done=%b expired=%b exp rem=%0d done=%b expired=%b",
                 k, rem1, done1, expired1, exp_rem, (k == 3), (k == 3));
        failures++;
      end
    end
    start = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_pause();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    test_prescale1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
